// File: rtl/mem_top.sv
// mem_top: CPU-side direct-mapped, write-back, write-allocate data cache
// with a 128-bit line port toward the DDR2 controller wrapper.
// Optional feature macro: CACHE_STATS_EN adds hit_count / miss_count outputs.
module mem_top #(
  parameter int INDEX_W = 8,
  parameter int ADDR_W  = 27
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [31:0]       cpu_req_data,
  input  logic              cpu_req_rw,
  input  logic              cpu_req_valid,
  output logic [31:0]       cpu_res_data,
  output logic              cpu_res_ready,
  input  logic              mem_calib_done,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [127:0]      mem_req_data,
  input  logic              mem_req_ready,
  input  logic              mem_res_valid,
  input  logic [127:0]      mem_res_data,
`ifdef CACHE_STATS_EN
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
`endif
  output logic              led
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 4;

  // Word 0 of a line sits in bits [31:0], matching the DDR2 line bus.
  typedef logic [3:0][31:0] line_t;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE,
    S_FILL_WAIT
  } state_t;

  // Line storage: valid, dirty, tag and data per index.
  logic             valid_mem [LINES];
  logic             dirty_mem [LINES];
  logic [TAG_W-1:0] tag_mem   [LINES];
  line_t            data_mem  [LINES];

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] clear_idx_q, clear_idx_d;
  logic               clear_done_q, clear_done_d;
  // The request is held as a word address; byte-offset bits are dropped.
  logic [ADDR_W-3:0]  req_waddr_q, req_waddr_d;
  logic [31:0]        req_data_q, req_data_d;
  logic               req_rw_q, req_rw_d;
  logic               cpu_res_ready_q, cpu_res_ready_d;
  logic [31:0]        cpu_res_data_q, cpu_res_data_d;
  logic               mem_req_valid_q, mem_req_valid_d;
  logic               mem_req_rw_q, mem_req_rw_d;
  logic [ADDR_W-1:0]  mem_req_addr_q, mem_req_addr_d;
  logic [127:0]       mem_req_data_q, mem_req_data_d;
  logic               led_q, led_d;
`ifdef CACHE_STATS_EN
  logic               from_idle_q, from_idle_d;
  logic [31:0]        hit_count_q, hit_count_d;
  logic [31:0]        miss_count_q, miss_count_d;
`endif

  // Line-write port shared by clear, write hit and refill.
  logic               line_we;
  logic [INDEX_W-1:0] line_widx;
  logic               line_wvalid;
  logic               line_wdirty;
  logic [TAG_W-1:0]   line_wtag;
  line_t              line_wdata;

  // Byte-offset bits of the CPU address carry no information for word accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_req_addr[1:0];

  // Fields of the latched request and the line currently selected by it.
  logic [1:0]         req_word;
  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               cur_valid;
  logic               cur_dirty;
  logic [TAG_W-1:0]   cur_tag;
  line_t              cur_line;
  logic               hit;

  assign req_word  = req_waddr_q[1:0];
  assign req_idx   = req_waddr_q[INDEX_W+1:2];
  assign req_tag   = req_waddr_q[ADDR_W-3:INDEX_W+2];
  assign cur_valid = valid_mem[req_idx];
  assign cur_dirty = dirty_mem[req_idx];
  assign cur_tag   = tag_mem[req_idx];
  assign cur_line  = data_mem[req_idx];
  assign hit       = cur_valid && (cur_tag == req_tag);

  // Next-state, output and line-write decode for the cache controller.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d         = state_q;
    clear_idx_d     = clear_idx_q;
    clear_done_d    = clear_done_q;
    req_waddr_d     = req_waddr_q;
    req_data_d      = req_data_q;
    req_rw_d        = req_rw_q;
    cpu_res_ready_d = 1'b0;
    cpu_res_data_d  = cpu_res_data_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_rw_d    = mem_req_rw_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_data_d  = mem_req_data_q;
    led_d           = mem_calib_done;
`ifdef CACHE_STATS_EN
    from_idle_d     = from_idle_q;
    hit_count_d     = hit_count_q;
    miss_count_d    = miss_count_q;
`endif
    line_we         = 1'b0;
    line_widx       = req_idx;
    line_wvalid     = cur_valid;
    line_wdirty     = cur_dirty;
    line_wtag       = cur_tag;
    line_wdata      = cur_line;

    unique case (state_q)
      S_INIT: begin
        if (!clear_done_q) begin
          line_we      = 1'b1;
          line_widx    = clear_idx_q;
          line_wvalid  = 1'b0;
          line_wdirty  = 1'b0;
          line_wtag    = '0;
          line_wdata   = '0;
          clear_idx_d  = clear_idx_q + 1'b1;
          clear_done_d = &clear_idx_q;
        end else if (mem_calib_done) begin
          state_d = S_IDLE;
        end
      end

      S_IDLE: begin
        // The completion cycle does not re-sample a request still held high.
        if (cpu_req_valid && !cpu_res_ready_q) begin
          req_waddr_d = cpu_req_addr[ADDR_W-1:2];
          req_data_d  = cpu_req_data;
          req_rw_d    = cpu_req_rw;
`ifdef CACHE_STATS_EN
          from_idle_d = 1'b1;
`endif
          state_d     = S_COMPARE;
        end
      end

      S_COMPARE: begin
`ifdef CACHE_STATS_EN
        from_idle_d = 1'b0;
        if (from_idle_q) begin
          if (hit) hit_count_d  = hit_count_q + 32'd1;
          else     miss_count_d = miss_count_q + 32'd1;
        end
`endif
        if (hit) begin
          cpu_res_ready_d = 1'b1;
          if (req_rw_q) begin
            line_we              = 1'b1;
            line_wdirty          = 1'b1;
            line_wdata[req_word] = req_data_q;
          end else begin
            cpu_res_data_d = cur_line[req_word];
          end
          state_d = S_IDLE;
        end else if (cur_valid && cur_dirty) begin
          mem_req_valid_d = 1'b1;
          mem_req_rw_d    = 1'b1;
          mem_req_addr_d  = {cur_tag, req_idx, 4'b0000};
          mem_req_data_d  = cur_line;
          state_d         = S_WRITEBACK;
        end else begin
          mem_req_valid_d = 1'b1;
          mem_req_rw_d    = 1'b0;
          mem_req_addr_d  = {req_tag, req_idx, 4'b0000};
          state_d         = S_ALLOCATE;
        end
      end

      S_WRITEBACK: begin
        // Victim accepted: turn the held request straight into the line read.
        if (mem_req_ready) begin
          mem_req_rw_d   = 1'b0;
          mem_req_addr_d = {req_tag, req_idx, 4'b0000};
          state_d        = S_ALLOCATE;
        end
      end

      S_ALLOCATE: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = S_FILL_WAIT;
        end
      end

      S_FILL_WAIT: begin
        if (mem_res_valid) begin
          line_we     = 1'b1;
          line_wvalid = 1'b1;
          line_wdirty = 1'b0;
          line_wtag   = req_tag;
          line_wdata  = mem_res_data;
          state_d     = S_COMPARE;
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  // Control and output registers; reset aborts any transaction in flight.
  always_ff @(posedge sys_clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q         <= S_INIT;
      clear_idx_q     <= '0;
      clear_done_q    <= 1'b0;
      req_waddr_q     <= '0;
      req_data_q      <= '0;
      req_rw_q        <= 1'b0;
      cpu_res_ready_q <= 1'b0;
      cpu_res_data_q  <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_rw_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_data_q  <= '0;
      led_q           <= 1'b0;
`ifdef CACHE_STATS_EN
      from_idle_q     <= 1'b0;
      hit_count_q     <= '0;
      miss_count_q    <= '0;
`endif
    end else begin
      state_q         <= state_d;
      clear_idx_q     <= clear_idx_d;
      clear_done_q    <= clear_done_d;
      req_waddr_q     <= req_waddr_d;
      req_data_q      <= req_data_d;
      req_rw_q        <= req_rw_d;
      cpu_res_ready_q <= cpu_res_ready_d;
      cpu_res_data_q  <= cpu_res_data_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_rw_q    <= mem_req_rw_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_data_q  <= mem_req_data_d;
      led_q           <= led_d;
`ifdef CACHE_STATS_EN
      from_idle_q     <= from_idle_d;
      hit_count_q     <= hit_count_d;
      miss_count_q    <= miss_count_d;
`endif
    end
  end

  // Line storage write port; contents are invalidated by the INIT sweep.
  always_ff @(posedge sys_clk) begin
    // NOTE: the arrays have no reset so they can map to RAM; validity comes from the clear sweep instead.
    if (line_we) begin
      valid_mem[line_widx] <= line_wvalid;
      dirty_mem[line_widx] <= line_wdirty;
      tag_mem[line_widx]   <= line_wtag;
      data_mem[line_widx]  <= line_wdata;
    end
  end

  assign cpu_res_ready = cpu_res_ready_q;
  assign cpu_res_data  = cpu_res_data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_rw    = mem_req_rw_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_data  = mem_req_data_q;
  assign led           = led_q;
`ifdef CACHE_STATS_EN
  assign hit_count     = hit_count_q;
  assign miss_count    = miss_count_q;
`endif

endmodule

// File: tb/tb_mem_top.sv
// tb_mem_top: directed, table-driven bench for mem_top with a small DDR2
// line-memory model answering the cache's line requests.
module tb_mem_top;

  localparam int ACK_LAT    = 2;
  localparam int ACC_BUDGET = 1000;

  typedef logic [3:0][31:0] line_t;

  typedef struct {
    logic        rw;
    logic [26:0] addr;
    logic [31:0] wdata;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    logic        exp_hit;
    logic        exp_wb;
    logic [26:0] exp_wb_addr;
    line_t       exp_wb_line;
    logic [26:0] exp_fill_addr;
  } vec_t;

  logic         sys_clk;
  logic         rst;
  logic [26:0]  cpu_req_addr;
  logic [31:0]  cpu_req_data;
  logic         cpu_req_rw;
  logic         cpu_req_valid;
  logic [31:0]  cpu_res_data;
  logic         cpu_res_ready;
  logic         mem_calib_done;
  logic         mem_req_valid;
  logic         mem_req_rw;
  logic [26:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_req_ready;
  logic         mem_res_valid;
  logic [127:0] mem_res_data;
  logic         led;

  int n_checks = 0;
  int n_errors = 0;

  // DDR model bookkeeping, observed by the main sequence.
  line_t        ddr [logic [26:0]];
  int           n_rd;
  int           n_wr;
  logic [26:0]  last_rd_addr;
  logic [26:0]  last_wr_addr;
  logic [127:0] last_wr_data;
  logic [127:0] last_res_data;
  logic         rd_acked;
  int           res_lat;

  mem_top dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_data   (cpu_req_data),
    .cpu_req_rw     (cpu_req_rw),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_res_data   (cpu_res_data),
    .cpu_res_ready  (cpu_res_ready),
    .mem_calib_done (mem_calib_done),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_ready  (mem_req_ready),
    .mem_res_valid  (mem_res_valid),
    .mem_res_data   (mem_res_data),
    .led            (led)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Power-on DDR contents: each word encodes its line address and word number.
  function automatic line_t pat(input logic [26:0] a);
    line_t l;
    for (int k = 0; k < 4; k++) l[k] = {5'b10100, a} | 32'(k);
    return l;
  endfunction

  function automatic line_t ddr_rd(input logic [26:0] a);
    if (ddr.exists(a)) return ddr[a];
    return pat(a);
  endfunction

  function automatic line_t with_word(input line_t l, input int k, input logic [31:0] w);
    line_t r;
    r    = l;
    r[k] = w;
    return r;
  endfunction

  function automatic vec_t mk(input logic rw, input logic [26:0] addr, input logic [31:0] wdata,
                              input logic chk_rdata, input logic [31:0] exp_rdata,
                              input logic exp_hit, input logic exp_wb,
                              input logic [26:0] exp_wb_addr, input line_t exp_wb_line,
                              input logic [26:0] exp_fill_addr);
    vec_t v;
    v.rw = rw; v.addr = addr; v.wdata = wdata;
    v.chk_rdata = chk_rdata; v.exp_rdata = exp_rdata;
    v.exp_hit = exp_hit; v.exp_wb = exp_wb;
    v.exp_wb_addr = exp_wb_addr; v.exp_wb_line = exp_wb_line;
    v.exp_fill_addr = exp_fill_addr;
    return v;
  endfunction

  // DDR2 controller model: accepts after ACK_LAT cycles, returns reads res_lat cycles later.
  initial begin : ddr_model
    logic         r_rw;
    logic [26:0]  r_addr;
    logic [127:0] r_data;
    mem_req_ready = 1'b0;
    mem_res_valid = 1'b0;
    mem_res_data  = '0;
    forever begin
      @(negedge sys_clk);
      if (mem_req_valid && !rst) begin
        r_rw   = mem_req_rw;
        r_addr = mem_req_addr;
        r_data = mem_req_data;
        repeat (ACK_LAT) @(negedge sys_clk);
        check("req_held_until_ready", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        @(negedge sys_clk);
        mem_req_ready = 1'b0;
        if (r_rw) begin
          ddr[r_addr]  = r_data;
          n_wr++;
          last_wr_addr = r_addr;
          last_wr_data = r_data;
        end else begin
          n_rd++;
          last_rd_addr = r_addr;
          rd_acked     = 1'b1;
          repeat (res_lat) @(negedge sys_clk);
          mem_res_data  = ddr_rd(r_addr);
          last_res_data = mem_res_data;
          mem_res_valid = 1'b1;
          @(negedge sys_clk);
          mem_res_valid = 1'b0;
        end
      end
    end
  end

  // One CPU access; lat counts cycles from presenting valid to seeing ready.
  task automatic do_access(input logic rw, input logic [26:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int lat, output logic saw_mreq);
    n_rd     = 0;
    n_wr     = 0;
    saw_mreq = 1'b0;
    lat      = 0;
    @(negedge sys_clk);
    cpu_req_addr  = addr;
    cpu_req_data  = wdata;
    cpu_req_rw    = rw;
    cpu_req_valid = 1'b1;
    do begin
      @(negedge sys_clk);
      lat++;
      if (mem_req_valid) saw_mreq = 1'b1;
    end while (!cpu_res_ready && lat < ACC_BUDGET);
    if (!cpu_res_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL access_timeout: addr %0h got no cpu_res_ready within %0d cycles", addr, ACC_BUDGET);
    end
    rdata         = cpu_res_data;
    cpu_req_valid = 1'b0;
    @(negedge sys_clk);
    check("ready_single_pulse", cpu_res_ready, 1'b0);
  endtask

  initial begin : main
    vec_t        vecs [11];
    logic [31:0] rdata;
    int          lat;
    logic        saw_mreq;
    logic        quiet;
    int          wait_cnt;

    rst            = 1'b1;
    mem_calib_done = 1'b0;
    cpu_req_addr   = '0;
    cpu_req_data   = '0;
    cpu_req_rw     = 1'b0;
    cpu_req_valid  = 1'b0;
    rd_acked       = 1'b0;
    res_lat        = 3;
    n_rd           = 0;
    n_wr           = 0;

    vecs[0]  = mk(1'b1, 27'h2AAAAAA, 32'h33333333, 1'b0, '0, 1'b0, 1'b0, '0, '0, 27'h2AAAAA0);
    vecs[1]  = mk(1'b0, 27'h2AAAAAA, '0, 1'b1, 32'h33333333, 1'b1, 1'b0, '0, '0, '0);
    vecs[2]  = mk(1'b1, 27'h0000AA8, 32'h0F0F0F0F, 1'b0, '0, 1'b0, 1'b1, 27'h2AAAAA0,
                  with_word(pat(27'h2AAAAA0), 2, 32'h33333333), 27'h0000AA0);
    vecs[3]  = mk(1'b0, 27'h2AAAAAA, '0, 1'b1, 32'h33333333, 1'b0, 1'b1, 27'h0000AA0,
                  with_word(pat(27'h0000AA0), 2, 32'h0F0F0F0F), 27'h2AAAAA0);
    vecs[4]  = mk(1'b0, 27'h2AAAAA4, '0, 1'b1, pat(27'h2AAAAA0)[1], 1'b1, 1'b0, '0, '0, '0);
    vecs[5]  = mk(1'b0, 27'h0001000, '0, 1'b1, pat(27'h0001000)[0], 1'b0, 1'b0, '0, '0, 27'h0001000);
    vecs[6]  = mk(1'b1, 27'h7FFFFFC, 32'hDEADBEEF, 1'b0, '0, 1'b0, 1'b0, '0, '0, 27'h7FFFFF0);
    vecs[7]  = mk(1'b0, 27'h7FFFFFF, '0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, '0, '0, '0);
    vecs[8]  = mk(1'b0, 27'h0000AA0, '0, 1'b1, pat(27'h0000AA0)[0], 1'b0, 1'b0, '0, '0, 27'h0000AA0);
    vecs[9]  = mk(1'b1, 27'h0000AA4, 32'h55555555, 1'b0, '0, 1'b1, 1'b0, '0, '0, '0);
    vecs[10] = mk(1'b0, 27'h2AAAAA8, '0, 1'b1, 32'h33333333, 1'b0, 1'b1, 27'h0000AA0,
                  with_word(with_word(pat(27'h0000AA0), 2, 32'h0F0F0F0F), 1, 32'h55555555),
                  27'h2AAAAA0);

    // Reset with calibration low: every output at its reset value.
    repeat (3) @(negedge sys_clk);
    check("rst_cpu_res_ready", cpu_res_ready, 1'b0);
    check("rst_cpu_res_data", cpu_res_data, 32'h0);
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_mem_req_rw", mem_req_rw, 1'b0);
    check("rst_mem_req_addr", mem_req_addr, 27'h0);
    check("rst_mem_req_data", mem_req_data, 128'h0);
    check("rst_led", led, 1'b0);

    // Out of reset but uncalibrated: stays quiet.
    rst   = 1'b0;
    quiet = 1'b1;
    repeat (300) begin
      @(negedge sys_clk);
      if (mem_req_valid || cpu_res_ready) quiet = 1'b0;
    end
    check("uncalibrated_quiet", quiet, 1'b1);
    check("led_before_calib", led, 1'b0);
    mem_calib_done = 1'b1;
    @(negedge sys_clk);
    check("led_after_calib", led, 1'b1);

    // Table of accesses with hand-derived traffic and data.
    for (int i = 0; i < 11; i++) begin
      do_access(vecs[i].rw, vecs[i].addr, vecs[i].wdata, rdata, lat, saw_mreq);
      if (vecs[i].chk_rdata) check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      if (vecs[i].exp_hit) begin
        check($sformatf("v%0d_hit_latency", i), lat, 2);
        check($sformatf("v%0d_hit_no_mem_req", i), saw_mreq, 1'b0);
      end else begin
        check($sformatf("v%0d_line_reads", i), n_rd, 1);
        check($sformatf("v%0d_fill_addr", i), last_rd_addr, vecs[i].exp_fill_addr);
        check($sformatf("v%0d_writebacks", i), n_wr, vecs[i].exp_wb ? 1 : 0);
        if (vecs[i].exp_wb) begin
          check($sformatf("v%0d_wb_addr", i), last_wr_addr, vecs[i].exp_wb_addr);
          check($sformatf("v%0d_wb_data", i), last_wr_data, vecs[i].exp_wb_line);
        end
        if (!vecs[i].rw) begin
          line_t fl;
          fl = last_res_data;
          check($sformatf("v%0d_rdata_from_fill", i), rdata, fl[vecs[i].addr[3:2]]);
        end
      end
    end

    // Reset while waiting for a fill: outputs drop, late response is ignored.
    res_lat  = 20;
    rd_acked = 1'b0;
    @(negedge sys_clk);
    cpu_req_addr  = 27'h1234564;
    cpu_req_rw    = 1'b0;
    cpu_req_valid = 1'b1;
    wait_cnt      = 0;
    while (!rd_acked && wait_cnt < 200) begin
      @(negedge sys_clk);
      wait_cnt++;
    end
    check("abort_read_issued", rd_acked, 1'b1);
    repeat (3) @(negedge sys_clk);
    rst           = 1'b1;
    cpu_req_valid = 1'b0;
    #1;
    check("abort_mem_req_valid", mem_req_valid, 1'b0);
    check("abort_mem_req_addr", mem_req_addr, 27'h0);
    check("abort_cpu_res_data", cpu_res_data, 32'h0);
    check("abort_led", led, 1'b0);
    repeat (2) @(negedge sys_clk);
    rst     = 1'b0;
    res_lat = 3;

    // Previously dirty line was discarded: fresh read, no write-back, waits out the clear.
    do_access(1'b0, 27'h7FFFFFC, '0, rdata, lat, saw_mreq);
    check("post_rst_lat_covers_clear", lat > 256, 1'b1);
    check("post_rst_line_reads", n_rd, 1);
    check("post_rst_no_writeback", n_wr, 0);
    check("post_rst_fill_addr", last_rd_addr, 27'h7FFFFF0);
    check("post_rst_rdata", rdata, pat(27'h7FFFFF0)[3]);

    // The aborted address misses again with a fresh line read.
    do_access(1'b0, 27'h1234564, '0, rdata, lat, saw_mreq);
    check("abort_addr_line_reads", n_rd, 1);
    check("abort_addr_fill_addr", last_rd_addr, 27'h1234560);
    check("abort_addr_rdata", rdata, pat(27'h1234560)[1]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
